// File: rtl/cursor_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cursor_ctrl_pkg
// Shared definitions for the cursor controller slice.
//   - state_e   : movement FSM states (IDLE, WAIT_FRAME, APPLY)
//   - SCREEN_W/H: visible VGA area in pixels (640x480)
//   - ARROW_W/H : arrow sprite footprint in pixels (7x10)
//   - POS_SCALE : position sub-pixel scale (positions are in 1/10 pixel)
//   - POS_W     : width of the position outputs
// ---------------------------------------------------------------------------
package cursor_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    APPLY      = 2'd2
  } state_e;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int ARROW_W   = 7;
  localparam int ARROW_H   = 10;
  localparam int POS_SCALE = 10;
  localparam int POS_W     = 14;

endpackage

// File: rtl/cursor_ctrl_frame_tick.sv
// ---------------------------------------------------------------------------
// frame_tick_det
// Produces a single clk-cycle tick at the start of vertical blanking.
// The condition (v_cnt == SCREEN_H && h_cnt == 0) is registered and its
// rising edge is taken, so the tick is one cycle long no matter how many
// clk cycles the pixel counters hold that value.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset, clears the edge history
//   h_cnt_i : VGA horizontal pixel counter
//   v_cnt_i : VGA vertical line counter
//   tick_o  : one-cycle frame tick
// ---------------------------------------------------------------------------
module frame_tick_det
  import cursor_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_cnt_i,
  input  logic [9:0] v_cnt_i,
  output logic       tick_o
);

  logic cond_q;
  logic cond_prev_q;

  // Register the raw condition, then keep one cycle of history for the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_q      <= 1'b0;
      cond_prev_q <= 1'b0;
    end else begin
      cond_q      <= (v_cnt_i == 10'(SCREEN_H)) && (h_cnt_i == 10'd0);
      cond_prev_q <= cond_q;
    end
  end

  assign tick_o = cond_q & ~cond_prev_q;

endmodule

// File: rtl/cursor_ctrl.sv
// ---------------------------------------------------------------------------
// cursor_ctrl
// Moves a mouse-style cursor from four held buttons, updating the position
// at most once per video frame (at the start of vertical blanking) so the
// overlay never sees the cursor jump during active video.
// Optional build macro: CURSOR_ACCEL_EN adds a held-frame counter that
// doubles / quadruples the step after 16 / 32 consecutive moving frames.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   h_cnt, v_cnt              : VGA pixel / line counters
//   btn_up/down/left/right    : debounced level buttons
//   h_position, v_position    : cursor position in 1/10-pixel units
//   pos_update                : one-cycle pulse when the position changed
//   moving                    : high while the FSM is not idle
// ---------------------------------------------------------------------------
module cursor_ctrl
  import cursor_ctrl_pkg::*;
#(
  parameter int unsigned STEP   = POS_SCALE,
  parameter int unsigned H_MAX  = (SCREEN_W - ARROW_W) * POS_SCALE,
  parameter int unsigned V_MAX  = (SCREEN_H - ARROW_H) * POS_SCALE,
  parameter int unsigned H_INIT = (SCREEN_W / 2) * POS_SCALE,
  parameter int unsigned V_INIT = (SCREEN_H / 2) * POS_SCALE
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  output logic [POS_W-1:0] h_position,
  output logic [POS_W-1:0] v_position,
  output logic             pos_update,
  output logic             moving
);

  localparam logic [14:0] STEP15  = 15'(STEP);
  localparam logic [14:0] H_MAX15 = 15'(H_MAX);
  localparam logic [14:0] V_MAX15 = 15'(V_MAX);

  state_e           state_q, state_d;
  logic [POS_W-1:0] h_q, h_d, v_q, v_d;
  logic             pos_update_q, pos_update_d;
  logic             frame_tick;
  logic             any_btn;
  logic [14:0]      step;
  logic [14:0]      h_ext, v_ext, h_next, v_next;

  assign any_btn = btn_up | btn_down | btn_left | btn_right;

  frame_tick_det u_frame_tick (
    .clk     (clk),
    .rst     (rst),
    .h_cnt_i (h_cnt),
    .v_cnt_i (v_cnt),
    .tick_o  (frame_tick)
  );

`ifdef CURSOR_ACCEL_EN
  logic [5:0] hold_q, hold_d;

  // Step grows with the number of frames the cursor has been moving.
  // The count seen here is the value before this APPLY's increment.
  always_comb begin
    if (hold_q < 6'd16)      step = STEP15;
    else if (hold_q < 6'd32) step = STEP15 << 1;
    else                     step = STEP15 << 2;
  end

  // Held-frame counter: saturating increment per APPLY, cleared whenever
  // the FSM falls back to IDLE (clear wins over the increment)
  always_comb begin
    hold_d = hold_q;
    if (state_q == APPLY && hold_q != 6'd63) hold_d = hold_q + 6'd1;
    if (state_d == IDLE && state_q != IDLE)  hold_d = 6'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= 6'd0;
    else     hold_q <= hold_d;
  end
`else
  assign step = STEP15;
`endif

  // Candidate positions for this cycle. Opposing buttons cancel on their
  // axis; 15-bit math lets the increment overflow H_MAX/V_MAX before the
  // clamp, and the decrement clamps to 0 instead of wrapping.
  always_comb begin
    h_ext = {1'b0, h_q};
    v_ext = {1'b0, v_q};

    h_next = h_ext;
    if (btn_right && !btn_left)
      h_next = ((h_ext + step) > H_MAX15) ? H_MAX15 : (h_ext + step);
    else if (btn_left && !btn_right)
      h_next = (h_ext < step) ? 15'd0 : (h_ext - step);

    v_next = v_ext;
    if (btn_down && !btn_up)
      v_next = ((v_ext + step) > V_MAX15) ? V_MAX15 : (v_ext + step);
    else if (btn_up && !btn_down)
      v_next = (v_ext < step) ? 15'd0 : (v_ext - step);
  end

  // Movement FSM: wait for a frame tick while any button is held, then
  // spend exactly one cycle committing the move
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    pos_update_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_btn) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!any_btn)        state_d = IDLE;
        else if (frame_tick) state_d = APPLY;
      end
      APPLY: begin
        h_d          = h_next[POS_W-1:0];
        v_d          = v_next[POS_W-1:0];
        pos_update_d = (h_next != h_ext) || (v_next != v_ext);
        state_d      = any_btn ? WAIT_FRAME : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      h_q          <= POS_W'(H_INIT);
      v_q          <= POS_W'(V_INIT);
      pos_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      pos_update_q <= pos_update_d;
    end
  end

  assign h_position = h_q;
  assign v_position = v_q;
  assign pos_update = pos_update_q;
  assign moving     = (state_q != IDLE);

endmodule

// File: tb/tb_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cursor_ctrl
// Drives compressed VGA frames (FRAME_LEN clocks each, with the blanking
// condition held for several clocks) and button patterns changed mid-frame.
// A frame-level model predicts the position, the pulse and moving flag.
// ---------------------------------------------------------------------------
module tb_cursor_ctrl;

  localparam int FRAME_LEN = 24;
  localparam int STEP      = 10;
  localparam int H_MAX     = 6330;
  localparam int V_MAX     = 4700;
  localparam int H_INIT    = 3200;
  localparam int V_INIT    = 2400;

  // Button vector layout: {up, down, left, right}
  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [13:0] h_position, v_position;
  logic        pos_update, moving;

  int total = 0;
  int bad   = 0;

  int modelH    = H_INIT;
  int modelV    = V_INIT;
  int modelHold = 0;
  logic [3:0] curBtns = 4'b0000;
  int pulsesInFrame = 0;
  int totalPulses   = 0;

  cursor_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .h_position (h_position),
    .v_position (v_position),
    .pos_update (pos_update),
    .moving     (moving)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int stepFor(input int hold);
`ifdef CURSOR_ACCEL_EN
    if (hold < 16) return STEP;
    if (hold < 32) return 2 * STEP;
    return 4 * STEP;
`else
    return (hold >= 0) ? STEP : STEP;
`endif
  endfunction

  function automatic int moveAxis(input int pos, input bit inc, input bit dec,
                                  input int step, input int maxv);
    if (inc && !dec) return (pos + step > maxv) ? maxv : pos + step;
    if (dec && !inc) return (pos < step) ? 0 : pos - step;
    return pos;
  endfunction

  // One clock of stimulus at the falling edge: first observe the pulse
  // produced by the previous rising edges, then drive frame position fc
  task automatic applyStimulus(input int fc, input bit rstAtApply);
    @(negedge clk);
    if (pos_update === 1'b1) begin
      pulsesInFrame++;
      totalPulses++;
      checkOutput("pulseAlign", fc, 3);
    end
    if (fc < 3) begin
      v_cnt = 10'd480;
      h_cnt = 10'd0;
    end else if (fc == 8) begin
      v_cnt = 10'd480;
      h_cnt = 10'(1 + $urandom_range(0, 600));
    end else if (fc == 12) begin
      v_cnt = 10'($urandom_range(0, 479));
      h_cnt = 10'd0;
    end else begin
      v_cnt = 10'(481 + $urandom_range(0, 40));
      h_cnt = 10'($urandom_range(0, 799));
    end
    rst = rstAtApply && (fc >= 2) && (fc < 6);
  endtask

  // One frame: the tick uses the buttons held since the previous frame,
  // and nextBtns is applied halfway through this frame
  task automatic runFrame(input logic [3:0] nextBtns, input bit rstAtApply);
    int expPulse;
    int newH, newV, step;
    if (rstAtApply) begin
      modelH = H_INIT;
      modelV = V_INIT;
      modelHold = 0;
      expPulse = 0;
    end else if (curBtns != 4'b0000) begin
      step = stepFor(modelHold);
      newH = moveAxis(modelH, curBtns[0], curBtns[1], step, H_MAX);
      newV = moveAxis(modelV, curBtns[2], curBtns[3], step, V_MAX);
      expPulse = ((newH != modelH) || (newV != modelV)) ? 1 : 0;
      modelH = newH;
      modelV = newV;
      modelHold = (modelHold < 63) ? modelHold + 1 : 63;
    end else begin
      expPulse = 0;
      modelHold = 0;
    end
    pulsesInFrame = 0;
    for (int fc = 0; fc < FRAME_LEN; fc++) begin
      applyStimulus(fc, rstAtApply);
      if (fc == 16) begin
        {btn_up, btn_down, btn_left, btn_right} = nextBtns;
        curBtns = nextBtns;
      end
      if (fc == 20) checkOutput("moving", int'(moving), (nextBtns != 4'b0000) ? 1 : 0);
    end
    checkOutput("hPos", int'(h_position), modelH);
    checkOutput("vPos", int'(v_position), modelV);
    checkOutput("pulseCount", pulsesInFrame, expPulse);
  endtask

  task automatic holdFrames(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) runFrame(b, 1'b0);
    runFrame(4'b0000, 1'b0);
  endtask

  int pulsesBefore;
  int hBefore, vBefore;

  initial begin
    rst = 1'b1;
    h_cnt = 10'd0;
    v_cnt = 10'd0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstH", int'(h_position), H_INIT);
    checkOutput("rstV", int'(v_position), V_INIT);
    checkOutput("rstMoving", int'(moving), 0);
    checkOutput("rstPulse", int'(pos_update), 0);
    runFrame(4'b0000, 1'b0);

    $display("[TB] right held for three frames");
    pulsesBefore = totalPulses;
    holdFrames(B_RIGHT, 3);
    checkOutput("rightThreeH", int'(h_position), 3230);
    checkOutput("rightThreePulses", totalPulses - pulsesBefore, 3);

    $display("[TB] left+right+down for one frame");
    hBefore = int'(h_position);
    vBefore = int'(v_position);
    pulsesBefore = totalPulses;
    holdFrames(B_LEFT | B_RIGHT | B_DOWN, 1);
    checkOutput("cancelH", int'(h_position), hBefore);
    checkOutput("cancelV", int'(v_position), vBefore + 10);
    checkOutput("cancelPulses", totalPulses - pulsesBefore, 1);

    $display("[TB] reset during apply");
    runFrame(B_RIGHT, 1'b0);
    runFrame(B_RIGHT, 1'b1);
    checkOutput("rstApplyH", int'(h_position), H_INIT);
    checkOutput("rstApplyV", int'(v_position), V_INIT);
    runFrame(4'b0000, 1'b0);

    $display("[TB] clamp left to zero");
    holdFrames(B_LEFT, 340);
    checkOutput("clampLeft", int'(h_position), 0);
    $display("[TB] clamp down to V_MAX");
    holdFrames(B_DOWN, 240);
    checkOutput("clampDown", int'(v_position), V_MAX);
    $display("[TB] clamp right to H_MAX");
    holdFrames(B_RIGHT, 640);
    checkOutput("clampRight", int'(h_position), H_MAX);

`ifdef CURSOR_ACCEL_EN
    $display("[TB] acceleration from v=0");
    holdFrames(B_UP, 200);
    checkOutput("accelStart", int'(v_position), 0);
    holdFrames(B_DOWN, 40);
    checkOutput("accelForty", int'(v_position), 800);
`endif

    $display("[TB] randomized frames");
    for (int i = 0; i < 300; i++) begin
      logic [3:0] b;
      bit rstA;
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) b = 4'b0000;
      rstA = ($urandom_range(0, 24) == 0);
      runFrame(b, rstA);
    end
    runFrame(4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
